// File: rtl/a51_pkg.sv
// Shared constants, tap masks and state encoding for the A5/1 stream decryptor.
package a51_pkg;

  localparam int R1_LEN    = 19;
  localparam int R2_LEN    = 22;
  localparam int R3_LEN    = 23;
  localparam int KEY_LEN   = 64;
  localparam int FRAME_LEN = 22;

  // Clocking-bit indices used by the majority vote
  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  // Feedback tap masks: R1 {18,17,16,13}, R2 {21,20}, R3 {22,21,20,7}
  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_KEY   = 3'd1,
    LOAD_FRAME = 3'd2,
    MIX        = 3'd3,
    GEN        = 3'd4,
    WAIT_IN    = 3'd5,
    WAIT_OUT   = 3'd6,
    DONE       = 3'd7
  } state_t;

  typedef enum logic {
    MODE_LOAD = 1'b0,
    MODE_MAJ  = 1'b1
  } core_mode_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a51_stream_decrypt_if.sv
// Ciphertext-in / plaintext-out byte stream handshake of the A5/1 decryptor.
interface a51_stream_decrypt_if;

  logic [7:0] cipher_in;
  logic       cipher_valid;
  logic       cipher_ready;
  logic [7:0] plain_out;
  logic       plain_valid;
  logic       plain_ready;

  modport master (
    output cipher_in, cipher_valid, plain_ready,
    input  cipher_ready, plain_out, plain_valid
  );

  modport slave (
    input  cipher_in, cipher_valid, plain_ready,
    output cipher_ready, plain_out, plain_valid
  );

endinterface

// File: rtl/a51_core.sv
// The three A5/1 LFSRs with load-mode and majority-mode clocking.
// ks_bit is the output bit of the register contents after the current step.
module a51_core
  import a51_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  core_mode_t mode,
  input  logic       step,
  input  logic       load_bit,
  output logic       ks_bit
);

  logic [R1_LEN-1:0] r1_r, r1_next_s;
  logic [R2_LEN-1:0] r2_r, r2_next_s;
  logic [R3_LEN-1:0] r3_r, r3_next_s;
  logic              maj_s, clk1_s, clk2_s, clk3_s, in_bit_s;

  // Next-state of each register from clocking mode, majority vote and feedback
  always_comb begin
    maj_s = maj3(r1_r[R1_CLK], r2_r[R2_CLK], r3_r[R3_CLK]);
    if (mode == MODE_LOAD) begin
      clk1_s   = step;
      clk2_s   = step;
      clk3_s   = step;
      in_bit_s = load_bit;
    end else begin
      clk1_s   = step && (r1_r[R1_CLK] == maj_s);
      clk2_s   = step && (r2_r[R2_CLK] == maj_s);
      clk3_s   = step && (r3_r[R3_CLK] == maj_s);
      in_bit_s = 1'b0;
    end
    r1_next_s = clk1_s ? {r1_r[R1_LEN-2:0], (^(r1_r & R1_TAPS)) ^ in_bit_s} : r1_r;
    r2_next_s = clk2_s ? {r2_r[R2_LEN-2:0], (^(r2_r & R2_TAPS)) ^ in_bit_s} : r2_r;
    r3_next_s = clk3_s ? {r3_r[R3_LEN-2:0], (^(r3_r & R3_TAPS)) ^ in_bit_s} : r3_r;
    ks_bit    = r1_next_s[R1_LEN-1] ^ r2_next_s[R2_LEN-1] ^ r3_next_s[R3_LEN-1];
  end

  // Register update with async reset and synchronous clear at session start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_r <= 19'd0;
      r2_r <= 22'd0;
      r3_r <= 23'd0;
    end else if (clear) begin
      r1_r <= 19'd0;
      r2_r <= 22'd0;
      r3_r <= 23'd0;
    end else begin
      r1_r <= r1_next_s;
      r2_r <= r2_next_s;
      r3_r <= r3_next_s;
    end
  end

endmodule

// File: rtl/a51_stream_decrypt.sv
// A5/1 receive path: key/frame setup and mixing, then one keystream byte per
// ciphertext byte, XORed and delivered over a valid/ready handshake.
module a51_stream_decrypt
  import a51_pkg::*;
#(
  parameter int MSG_BYTES  = 28,
  parameter int MIX_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_LEN-1:0]    key,
  input  logic [FRAME_LEN-1:0]  frame,
  a51_stream_decrypt_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            byte_count
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_LEN - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
  localparam logic [CNT_W-1:0] GEN_LAST   = CNT_W'(7);
  localparam logic [4:0]       BYTE_LAST  = 5'(MSG_BYTES - 1);

  state_t               state_r;
  logic [CNT_W-1:0]     step_cnt_r;
  logic [KEY_LEN-1:0]   key_r;
  logic [FRAME_LEN-1:0] frame_r;
  logic [7:0]           ks_r;
  logic [7:0]           plain_out_r;
  logic                 cipher_ready_r, plain_valid_r;
  logic                 core_clear_s, core_step_s, load_bit_s, ks_bit_s;
  core_mode_t           core_mode_s;

  assign bus.cipher_ready = cipher_ready_r;
  assign bus.plain_valid  = plain_valid_r;
  assign bus.plain_out    = plain_out_r;

  a51_core u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (core_clear_s),
    .mode     (core_mode_s),
    .step     (core_step_s),
    .load_bit (load_bit_s),
    .ks_bit   (ks_bit_s)
  );

  // Core control: key/frame bits are taken from the MSB of shifting copies
  always_comb begin
    core_clear_s = 1'b0;
    core_step_s  = 1'b0;
    core_mode_s  = MODE_MAJ;
    load_bit_s   = 1'b0;
    case (state_r)
      IDLE, DONE: core_clear_s = start;
      LOAD_KEY: begin
        core_step_s = 1'b1;
        core_mode_s = MODE_LOAD;
        load_bit_s  = key_r[KEY_LEN-1];
      end
      LOAD_FRAME: begin
        core_step_s = 1'b1;
        core_mode_s = MODE_LOAD;
        load_bit_s  = frame_r[FRAME_LEN-1];
      end
      MIX, GEN: core_step_s = 1'b1;
      default: core_step_s = 1'b0;
    endcase
  end

  // Sequencer, keystream byte assembly and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      step_cnt_r     <= 8'd0;
      key_r          <= 64'd0;
      frame_r        <= 22'd0;
      ks_r           <= 8'd0;
      plain_out_r    <= 8'd0;
      cipher_ready_r <= 1'b0;
      plain_valid_r  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      byte_count     <= 5'd0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            key_r      <= key;
            frame_r    <= frame;
            step_cnt_r <= 8'd0;
            byte_count <= 5'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state_r    <= LOAD_KEY;
          end
        end
        LOAD_KEY: begin
          key_r <= {key_r[KEY_LEN-2:0], 1'b0};
          if (step_cnt_r == KEY_LAST) begin
            step_cnt_r <= 8'd0;
            state_r    <= LOAD_FRAME;
          end else begin
            step_cnt_r <= step_cnt_r + 8'd1;
          end
        end
        LOAD_FRAME: begin
          frame_r <= {frame_r[FRAME_LEN-2:0], 1'b0};
          if (step_cnt_r == FRAME_LAST) begin
            step_cnt_r <= 8'd0;
            state_r    <= MIX;
          end else begin
            step_cnt_r <= step_cnt_r + 8'd1;
          end
        end
        MIX: begin
          if (step_cnt_r == MIX_LAST) begin
            step_cnt_r <= 8'd0;
            state_r    <= GEN;
          end else begin
            step_cnt_r <= step_cnt_r + 8'd1;
          end
        end
        GEN: begin
          ks_r <= {ks_r[6:0], ks_bit_s};
          if (step_cnt_r == GEN_LAST) begin
            step_cnt_r     <= 8'd0;
            cipher_ready_r <= 1'b1;
            state_r        <= WAIT_IN;
          end else begin
            step_cnt_r <= step_cnt_r + 8'd1;
          end
        end
        WAIT_IN: begin
          if (bus.cipher_valid) begin
            plain_out_r    <= bus.cipher_in ^ ks_r;
            plain_valid_r  <= 1'b1;
            cipher_ready_r <= 1'b0;
            state_r        <= WAIT_OUT;
          end
        end
        WAIT_OUT: begin
          if (bus.plain_ready) begin
            plain_valid_r <= 1'b0;
            byte_count    <= byte_count + 5'd1;
            if (byte_count == BYTE_LAST) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= GEN;
            end
          end
        end
        default: begin
          cipher_ready_r <= 1'b0;
          plain_valid_r  <= 1'b0;
          busy           <= 1'b0;
          done           <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/a51_stream_decrypt.md
Name: a51_stream_decrypt

Overview:
- Receive-side counterpart of the A5/1 encrypt path. It takes a 64-bit session key and a 22-bit frame number, then runs A5/1 setup: key load, frame load and 100-cycle mixing.
- After setup it generates keystream on demand and XORs it byte-by-byte with incoming ciphertext, producing plaintext over a valid/ready output handshake.
- Sits between a ciphertext byte source (PS2/UART capture or a stored 224-bit block reader) and the LCD character writer.

Parameters:
- MSG_BYTES, 28, number of bytes decrypted per start (28 bytes = 224 bits, matching the encrypt block size).
- MIX_CYCLES, 100, irregular-clocking cycles with output discarded.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; latches key and frame and begins setup (honoured in IDLE or DONE only)
- key  in  64  session key, loaded MSB (key[63]) first
- frame  in  22  frame number, loaded MSB (frame[21]) first
- cipher_in  in  8  ciphertext byte
- cipher_valid  in  1  cipher_in is valid
- cipher_ready  out  1  block accepts cipher_in this cycle
- plain_out  out  8  plaintext byte
- plain_valid  out  1  plain_out is valid
- plain_ready  in  1  sink accepts plain_out
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE; all MSG_BYTES bytes delivered
- byte_count  out  5  bytes delivered since start (0..MSG_BYTES)

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - R1, R2, R3, step counter, byte_count, keystream shift register and plain_out all go to 0.
  - cipher_ready, plain_valid, busy and done are all 0.
- Registers: R1 is 19 bits, R2 is 22 bits, R3 is 23 bits.
  - Each register shifts toward the MSB; the new bit enters at bit 0.
  - Feedback taps: R1 uses 18^17^16^13; R2 uses 21^20; R3 uses 22^21^20^7.
  - Clocking bits: R1[8], R2[10], R3[10].
  - Output bit = R1[18]^R2[21]^R3[22].
- States:
  - IDLE: on start, latch key/frame, clear R1–R3, counters and byte_count, then go to LOAD_KEY.
  - LOAD_KEY (64 cycles): all three registers clock every cycle; the input bit is feedback^key bit, key[63] first. Then go to LOAD_FRAME.
  - LOAD_FRAME (22 cycles): same as LOAD_KEY using frame bits, frame[21] first. Then go to MIX.
  - MIX (MIX_CYCLES): majority clocking; a register clocks iff its clocking bit equals maj(R1[8],R2[10],R3[10]). Output is discarded. Then go to GEN.
  - GEN (8 cycles): majority clocking; each output bit shifts into ks[0], so the first bit ends up as ks[7] (MSB-first). Then go to WAIT_IN.
  - WAIT_IN: cipher_ready=1 and registers are frozen. On cipher_valid, plain_out <= cipher_in ^ ks, plain_valid=1 next cycle, then go to WAIT_OUT.
  - WAIT_OUT: plain_valid is held and plain_out is stable. On plain_ready:
    - byte_count increments.
    - If byte_count reaches MSG_BYTES, go to DONE; otherwise go to GEN.
    - plain_valid drops in the next cycle.
  - DONE: done=1. A start pulse restarts exactly as from IDLE, and done drops in that next cycle.
- Timing:
  - Latency from start to the first cipher_ready is 1 + 64 + 22 + MIX_CYCLES + 8 cycles: cipher_ready rises 195 cycles after the edge that samples start (default).
  - Per-byte minimum throughput is 10 cycles (8 GEN + 1 WAIT_IN + 1 WAIT_OUT).
- cipher_ready and plain_valid are never high together.
- Boundary conditions:
  - start while busy: ignored, no state change.
  - cipher_valid outside WAIT_IN: ignored, nothing consumed.
  - plain_ready without plain_valid: no effect.
  - Registers never clock in WAIT_IN, WAIT_OUT, IDLE or DONE, so keystream position depends only on bytes delivered, not on backpressure duration.
  - Reset mid-operation: immediate return to IDLE with all reset values; the latched key is discarded.
  - All-zero key and frame: registers stay 0 and the keystream is all zeros (legal, no special case).

Decomposition:
- Shared package a51_pkg holds:
  - constants R1_LEN=19, R2_LEN=22, R3_LEN=23, KEY_LEN=64, FRAME_LEN=22;
  - tap positions and clocking-bit indices;
  - the state enum (IDLE, LOAD_KEY, LOAD_FRAME, MIX, GEN, WAIT_IN, WAIT_OUT, DONE).
- One sub-module, a51_core: the three registers plus majority logic.
  - Inputs: clk, reset, clear, mode (load/majority), step, load_bit.
  - Output: ks_bit.
  - The top-level FSM drives step/mode and owns the counters, ks shift register and handshake.

Test Plan:
- Zero vector: key=0, frame=0, cipher bytes 0x41..0x5C (28 bytes), plain_ready=1.
  - Expect plain_out equal to cipher_in for all 28 bytes.
  - Expect done=1 with byte_count=28, and first cipher_ready exactly 195 cycles after start.
- Round trip: key=64'h1223456789ABCDEF, frame=22'h134, ciphertext taken from the encrypt block (or a bit-exact model) of plaintext "HELLO WORLD…" (28 bytes).
  - Expect the original ASCII bytes back, in order.
- Backpressure: same vector as the round trip with plain_ready low 0–20 random cycles per byte and cipher_valid gaps.
  - Expect output identical to the round trip.
  - Expect plain_out stable while plain_valid=1 and !plain_ready.
- Restart and ignore: start pulse at cycle 50 (during LOAD_KEY) is ignored; start pulse in DONE with a new key produces a fresh correct stream.
  - After the restart, byte_count restarts at 0.
- Reset mid-stream: assert reset during byte 10 in WAIT_OUT.
  - Expect all outputs 0 asynchronously and state IDLE.
  - Expect a subsequent start with the same key to reproduce byte 0 correctly.
- Protocol check (assertion): cipher_ready && plain_valid never both high; busy = !(IDLE||DONE) at all times.
